// File: rtl/gambling_pkg.sv
// gambling_pkg: scan codes, keyboard word address and PS/2 frame states
package gambling_pkg;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam int DEF_KEY_ADDR = 10;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;
endpackage

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: PS/2 pin sync, clock glitch filter, frame FSM with odd parity and idle timeout
module ps2_rx_frame
  import gambling_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  frame_state_t state, state_nxt;
  logic [1:0] clk_s, dat_s;
  logic [FW-1:0] fcnt;
  logic [TW-1:0] tcnt;
  logic [7:0] shift;
  logic [2:0] bcnt;
  logic fclk, fclk_q, par, fall, d, tout, ok, err;
  assign d = dat_s[1];
  assign fall = fclk_q & ~fclk;
  assign tout = state != IDLE && !fall && tcnt == TW'(TIMEOUT_CYCLES - 1);
  assign byte_data = shift;
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s <= 2'b11;
      dat_s <= 2'b11;
      fcnt <= '0;
      fclk <= 1'b1;
      fclk_q <= 1'b1;
    end else begin
      clk_s <= {clk_s[0], ps2_clk};
      dat_s <= {dat_s[0], ps2_data};
      fclk_q <= fclk;
      fcnt <= (clk_s[1] == fclk || fcnt == FW'(FILTER_LEN - 1)) ? '0 : fcnt + 1'b1;
      if (clk_s[1] != fclk && fcnt == FW'(FILTER_LEN - 1)) fclk <= clk_s[1];
    end
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    if (tout) state_nxt = IDLE;
    else if (fall)
      case (state)
        IDLE: state_nxt = d ? IDLE : DATA;
        DATA: state_nxt = bcnt == 3'd7 ? PARITY : DATA;
        PARITY: state_nxt = STOP;
        STOP: state_nxt = IDLE;
      endcase
  end
  always_comb begin
    ok = state == STOP && fall && d && ^{par, shift};
    err = (state == STOP && fall && !ok) || tout;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      shift <= '0;
      bcnt <= '0;
      par <= 1'b0;
      tcnt <= '0;
      byte_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_valid <= ok;
      frame_err <= err;
      tcnt <= (state == IDLE || fall) ? '0 : tcnt + 1'b1;
      if (state == IDLE) bcnt <= '0;
      if (state == DATA && fall) begin
        shift <= {d, shift[7:1]};
        bcnt <= bcnt + 1'b1;
      end
      if (state == PARITY && fall) par <= d;
    end
  end
endmodule

// File: rtl/ps2_key_mmio.sv
// ps2_key_mmio: make/break decoder keeping the held-key word in data memory (PS2_EXTENDED_EN enables E0 keys)
module ps2_key_mmio
  import gambling_pkg::*;
#(
  parameter int KEY_ADDR = DEF_KEY_ADDR,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] key_word,
  output logic        frame_err
);
`ifdef PS2_EXTENDED_EN
  localparam bit EXT_EN = 1'b1;
`else
  localparam bit EXT_EN = 1'b0;
`endif
  logic byte_valid, brk, ext, is_brk, is_ext, we_c;
  logic [7:0] byte_data;
  logic [31:0] val, wd;
  ps2_rx_frame #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk(clk),
    .rst(rst),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .frame_err(frame_err)
  );
  always_comb begin
    is_brk = byte_data == SC_BREAK;
    is_ext = byte_data == SC_EXT;
    val = {23'b0, ext, byte_data};
    wd = brk ? '0 : val;
    // a break only clears the word when it names the key actually held
    we_c = byte_valid && !is_brk && !is_ext &&
           (brk ? (val == key_word && key_word != '0) : val != key_word);
  end
  assign mem_addr = mem_we ? 32'(KEY_ADDR) : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we <= 1'b0;
      mem_wdata <= '0;
      key_word <= '0;
      brk <= 1'b0;
      ext <= 1'b0;
    end else begin
      mem_we <= we_c;
      if (we_c) begin
        mem_wdata <= wd;
        key_word <= wd;
      end
      if (byte_valid) begin
        brk <= is_brk ? 1'b1 : is_ext ? brk : 1'b0;
        ext <= is_ext ? EXT_EN : is_brk ? ext : 1'b0;
      end
    end
  end
endmodule
